imem_boot_loader: RTL
=====================

# imem_boot_loader

Writes a program image into the MIPS core's instruction memory from an 8-bit byte stream, then releases the core from reset. The core reads instruction memory; this block is the writer on that interface. It holds the core in reset while loading, and releases it only after a frame passes its checksum.

## Interface
- ADDR_WIDTH, 8, word-address width of instruction memory; capacity is 2^ADDR_WIDTH words.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte; a byte transfers when in_valid && in_ready at a rising edge.
- imem_we  out  1  instruction-memory write strobe, one-cycle pulse.
- imem_addr  out  ADDR_WIDTH  word address of the write.
- imem_wdata  out  32  word to write.
- cpu_rst  out  1  reset to the core; high = core held in reset.
- busy  out  1  a frame is in progress.
- done  out  1  last frame loaded and checksum matched.
- error  out  1  last frame was rejected.
- words_loaded  out  ADDR_WIDTH+1  number of words written in the current or last frame.

## Operation
- Frame format: sync byte 0xA5, then LEN_HI and LEN_LO (16-bit big-endian word count N), then 4N data bytes, then CSUM.
- Data words are big-endian: the first byte goes to [31:24]. Word k goes to imem_addr k, so the image always starts at address 0.
- CSUM must equal the sum of all 4N data bytes mod 256. With N=0, CSUM must be 0x00.
- State machine states: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CSUM, DONE, ERR.
- IDLE, DONE, ERR:
  - Accepted bytes other than 0xA5 are discarded.
  - 0xA5 moves to LEN_HI and clears the checksum accumulator, byte counter, words_loaded, done and error. It sets busy and cpu_rst.
- LEN_HI → LEN_LO → (after LEN_LO):
  - N > 2^ADDR_WIDTH → ERR.
  - N = 0 → CSUM.
  - otherwise → DATA.
- DATA: shifts bytes into a 32-bit word and adds each byte to the 8-bit accumulator (wraps mod 256). The 4th byte of a word moves to WRITE.
- WRITE, one cycle:
  - imem_we=1, imem_addr=words_loaded[ADDR_WIDTH-1:0], imem_wdata=assembled word, in_ready=0.
  - words_loaded increments at the end of the cycle.
  - Next state is CSUM if words_loaded+1 == N, else DATA.
- CSUM: on match → DONE (done=1, cpu_rst=0, busy=0); on mismatch → ERR (error=1, cpu_rst=1, busy=0).
- Words already written before an ERR are left in memory. The core stays in reset until a later frame succeeds.
- A new 0xA5 received in DONE re-asserts cpu_rst immediately, so the core is reset before it is overwritten.
- 0xA5 bytes that arrive inside a frame are treated as data or length bytes. There is no resync mid-frame.

## Timing
- Reset values: in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, busy=0, done=0, error=0, words_loaded=0, state=IDLE.
- rst has priority over every transfer, including the cycle it is asserted, and aborts any frame in progress.
- All outputs are registered.
- imem_we pulses the cycle after the 4th byte of a word is accepted. It is never asserted in any other state.
- in_ready is 1 in every state except WRITE. Throughput is therefore 4 bytes per 5 cycles at full rate.
- done/error/cpu_rst update in the cycle after CSUM is accepted.
- cpu_rst rises in the cycle after 0xA5 is accepted from DONE.
- in_valid gaps of any length are allowed. State is held while in_valid=0.

## Test plan
- Reset, then stream A5 00 01 12 34 56 78 14 → one imem_we at addr 0 with data 0x12345678. Next cycle: done=1, cpu_rst=0, words_loaded=1.
- Stream A5 00 02 with words 0x00000001 and 0xFFFFFFFF and CSUM 0xFD → writes at addr 0 and 1. in_ready=0 during each write cycle; done=1.
- Same frame with CSUM 0x00 → both words written, then error=1, done=0, cpu_rst stays 1.
- With ADDR_WIDTH=8, stream A5 01 01 (N=257) → ERR after LEN_LO, no imem_we, error=1. Then A5 00 00 00 → done=1, words_loaded=0.
- Junk bytes 00 FF 5A before A5 are ignored. Random in_valid gaps are accepted with no lost or duplicated bytes.
- After done, send A5 → cpu_rst=1 next cycle. Assert rst mid-DATA → all outputs return to their reset values and no further imem_we occurs.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Receives a framed byte stream (0xA5, LEN_HI, LEN_LO, 4N data bytes, CSUM),
// writes the big-endian words into instruction memory starting at address 0,
// and keeps the core in reset until a frame's checksum matches.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0]            SYNC_BYTE = 8'hA5;
  // Largest legal word count is the full memory (2^ADDR_WIDTH words).
  localparam logic [32:0]           CAPACITY  = 33'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   WL_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t       state;
  logic [7:0]   len_hi;
  logic [15:0]  frame_len;
  logic [7:0]   csum_acc;
  logic [1:0]   byte_cnt;
  logic [31:0]  word_buf;

  logic         xfer;
  logic [15:0]  frame_len_n;
  logic         len_too_big;
  logic [ADDR_WIDTH:0] wl_inc;
  logic         last_word;
  logic [31:0]  word_next;

  // A byte moves only when both sides agree; in_ready is itself a register.
  assign xfer        = in_valid & in_ready;
  // Length formed in the LEN_LO cycle from the stored high byte and the incoming low byte.
  assign frame_len_n = {len_hi, in_data};
  assign len_too_big = (33'(frame_len_n) > CAPACITY);
  assign wl_inc      = words_loaded + WL_ONE;
  // Compared at full width so the count never wraps against a 16-bit length.
  assign last_word   = (32'(wl_inc) == 32'(frame_len));
  // Big-endian assembly: earlier bytes shift toward bit 31.
  assign word_next   = {word_buf[23:0], in_data};

  // Frame parser, memory writer and status registers in one state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      len_hi       <= 8'h00;
      frame_len    <= 16'h0000;
      csum_acc     <= 8'h00;
      byte_cnt     <= 2'd0;
      word_buf     <= 32'h0000_0000;
      in_ready     <= 1'b1;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'h0000_0000;
      cpu_rst      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      // The write strobe lives for exactly one cycle and in_ready only drops in WRITE.
      imem_we  <= 1'b0;
      in_ready <= 1'b1;

      case (state)
        IDLE, DONE, ERR: begin
          // Only the sync byte opens a frame; anything else is dropped.
          // Starting from DONE re-asserts cpu_rst before any word is overwritten.
          if (xfer && (in_data == SYNC_BYTE)) begin
            state        <= LEN_HI;
            csum_acc     <= 8'h00;
            byte_cnt     <= 2'd0;
            words_loaded <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            busy         <= 1'b1;
            cpu_rst      <= 1'b1;
          end
        end

        LEN_HI: begin
          if (xfer) begin
            len_hi <= in_data;
            state  <= LEN_LO;
          end
        end

        LEN_LO: begin
          if (xfer) begin
            frame_len <= frame_len_n;
            if (len_too_big) begin
              state   <= ERR;
              error   <= 1'b1;
              busy    <= 1'b0;
              cpu_rst <= 1'b1;
            end else if (frame_len_n == 16'h0000) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (xfer) begin
            word_buf <= word_next;
            csum_acc <= csum_acc + in_data;
            byte_cnt <= byte_cnt + 2'd1;
            // Fourth byte completes the word: present it to memory next cycle.
            if (byte_cnt == 2'd3) begin
              state      <= WRITE;
              imem_we    <= 1'b1;
              imem_addr  <= words_loaded[ADDR_WIDTH-1:0];
              imem_wdata <= word_next;
              in_ready   <= 1'b0;
            end
          end
        end

        WRITE: begin
          words_loaded <= wl_inc;
          if (last_word) begin
            state <= CSUM;
          end else begin
            state <= DATA;
          end
        end

        CSUM: begin
          if (xfer) begin
            busy <= 1'b0;
            if (in_data == csum_acc) begin
              state   <= DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state   <= ERR;
              error   <= 1'b1;
              cpu_rst <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
